elbeth_pipeline_ctrl: RTL and testbench
=======================================

ELBETH_PIPELINE_CTRL -- requirements
Module: elbeth_pipeline_ctrl

Interface
REQ-001 Parameter CNT_W, default 16: width of the stall-cycle performance counter, legal range 8..32.
REQ-002 Ports, clock and reset first:
- clk  in  1  sole clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_rs1, id_rs2  in  5 each  ID-stage source register addresses.
- id_use_rs1, id_use_rs2  in  1 each  ID instruction actually reads rs1/rs2.
- exs_rd_addr  in  5  EX-stage destination register.
- exs_w_gpr_en  in  1  EX instruction writes the GPR file.
- exs_mem_rd  in  1  EX instruction is a load.
- exs_mem_req  in  1  EX instruction issues a data-memory access.
- dmem_ready  in  1  data memory completes the access this cycle.
- exs_branch_taken  in  1  EX resolves a taken branch or jump.
- if_stall  out  1  hold PC and IF/ID register.
- id_stall  out  1  hold ID/EX inputs.
- exs_stall  out  1  hold EX stage.
- if_flush  out  1  squash IF/ID contents to NOP.
- id_bubble  out  1  inject NOP into ID/EX.
- match_forward_rs1, match_forward_rs2  out  1 each  select EX-result bypass for rs1/rs2.
- stall_count  out  CNT_W  saturating count of cycles with if_stall=1.
- ctrl_state  out  2  current FSM state encoding.

Function
REQ-003 FSM states and encodings: RUN=0, MEM_WAIT=1, FLUSH=2; encoding 3 unreachable and SHALL return to RUN on the next edge.
REQ-004 A hit on rsN means: id_use_rsN=1, exs_rd_addr==id_rsN, exs_rd_addr!=0, exs_w_gpr_en=1.
REQ-005 Stall, flush, bubble and forward outputs are combinational from the current state and inputs, with same-cycle effect; the next state is registered.
REQ-006 Event priority in RUN: memory wait > taken branch > load-use > none.
REQ-007 RUN with exs_mem_req=1 and dmem_ready=0:
- if_stall=id_stall=exs_stall=1;
- next state MEM_WAIT;
- exs_branch_taken ignored this cycle.
REQ-008 MEM_WAIT with dmem_ready=0: all three stalls stay 1 and the state holds.
REQ-009 MEM_WAIT with dmem_ready=1:
- all stalls 0 in that cycle;
- if exs_branch_taken=1 in that cycle, apply REQ-010 flush behaviour and go to FLUSH, else go to RUN.
REQ-010 RUN with exs_branch_taken=1 (no memory wait):
- if_flush=1 and id_bubble=1 that cycle;
- load the flush counter with 1;
- next state FLUSH.
REQ-011 FLUSH: if_flush=1 and stalls=0 each cycle; decrement the counter; return to RUN after the cycle in which the counter is 0, giving exactly 2 FLUSH cycles. A taken branch in FLUSH is ignored because EX holds a bubble.
REQ-012 RUN load-use (exs_mem_rd=1 and a hit on either rs):
- if_stall=id_stall=1 and id_bubble=1 for one cycle;
- exs_stall=0;
- state stays RUN.
REQ-013 match_forward_rsN=1 on a hit with exs_mem_rd=0; forced 0 whenever id_bubble=1 or in MEM_WAIT.
REQ-014 stall_count increments by 1 on each edge where if_stall=1, saturates at all-ones and never wraps.
REQ-015 ctrl_state reflects the registered state.

Reset
REQ-016 While rst=1, all stall, flush, bubble and forward outputs are 0.
REQ-017 While rst=1, state=RUN, flush counter=0 and stall_count=0 at the next edge.
REQ-018 Reset asserted in MEM_WAIT or FLUSH aborts the operation; RUN applies on the first cycle after rst falls.

Configuration
REQ-019 Macro ELBETH_FWD_EN, when defined, enables bypass per REQ-012 and REQ-013.
REQ-020 Without ELBETH_FWD_EN:
- match_forward_rs1/rs2 are tied 0;
- any hit (load or not) produces the REQ-012 one-cycle bubble;
- all other behaviour is unchanged.

Verification
REQ-021 ELBETH_FWD_EN defined; exs_rd_addr=5, exs_w_gpr_en=1, exs_mem_rd=0, id_rs1=5, id_use_rs1=1 -> match_forward_rs1=1, no stall. Same with exs_rd_addr=0 -> match_forward_rs1=0.
REQ-022 exs_mem_rd=1, exs_rd_addr=7, id_rs2=7, id_use_rs2=1 -> one cycle with if_stall=id_stall=id_bubble=1 and match_forward_rs2=0; stall_count goes 0->1.
REQ-023 exs_mem_req=1, dmem_ready=0 for 3 cycles, then 1 -> exactly 3 cycles of all stalls, ctrl_state 1 then 0; stall_count=3.
REQ-024 exs_branch_taken=1 in RUN -> if_flush=1 for 3 consecutive cycles (entry + 2 FLUSH) and id_bubble=1 in the first; ctrl_state 0,2,2,0.
REQ-025 Simultaneous exs_mem_req=1, dmem_ready=0, exs_branch_taken=1 and a load-use hit -> memory wait wins: if_flush=0, id_bubble=0. rst=1 asserted during MEM_WAIT -> all outputs 0, stall_count=0, ctrl_state=0.
REQ-026 CNT_W=8 with if_stall held high for 300 cycles -> stall_count=255, no wrap; repeat REQ-021 without ELBETH_FWD_EN -> forward outputs 0 and one bubble cycle.

Source files
------------

// File: rtl/elbeth_pipeline_ctrl.sv
// rtl/elbeth_pipeline_ctrl.sv - pipeline hazard/stall/flush controller with saturating stall counter
// Optional macro ELBETH_FWD_EN enables EX-result bypass; without it every RAW hit costs a bubble.
module elbeth_pipeline_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       exs_rd_addr,
  input  logic             exs_w_gpr_en,
  input  logic             exs_mem_rd,
  input  logic             exs_mem_req,
  input  logic             dmem_ready,
  input  logic             exs_branch_taken,
  output logic             if_stall,
  output logic             id_stall,
  output logic             exs_stall,
  output logic             if_flush,
  output logic             id_bubble,
  output logic             match_forward_rs1,
  output logic             match_forward_rs2,
  output logic [CNT_W-1:0] stall_count,
  output logic [1:0]       ctrl_state
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_BAD      = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q;

  logic hit_rs1, hit_rs2;
  logic bypass_rs1, bypass_rs2;
  logic load_hit, stall_hit;

  assign hit_rs1 = id_use_rs1 && exs_w_gpr_en && (exs_rd_addr != 5'd0) && (exs_rd_addr == id_rs1);
  assign hit_rs2 = id_use_rs2 && exs_w_gpr_en && (exs_rd_addr != 5'd0) && (exs_rd_addr == id_rs2);

  assign bypass_rs1 = hit_rs1 && !exs_mem_rd;
  assign bypass_rs2 = hit_rs2 && !exs_mem_rd;
  assign load_hit   = exs_mem_rd && (hit_rs1 || hit_rs2);

`ifdef ELBETH_FWD_EN
  assign stall_hit = load_hit;
`else
  // No bypass network: an ALU result dependency must also wait one cycle.
  assign stall_hit = load_hit || bypass_rs1 || bypass_rs2;
`endif

  always_comb begin
    if_stall    = 1'b0;
    id_stall    = 1'b0;
    exs_stall   = 1'b0;
    if_flush    = 1'b0;
    id_bubble   = 1'b0;
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    if (!rst) begin
      case (state_q)
        ST_RUN: begin
          if (exs_mem_req && !dmem_ready) begin
            if_stall  = 1'b1;
            id_stall  = 1'b1;
            exs_stall = 1'b1;
            state_d   = ST_MEM_WAIT;
          end else if (exs_branch_taken) begin
            if_flush    = 1'b1;
            id_bubble   = 1'b1;
            flush_cnt_d = 1'b1;
            state_d     = ST_FLUSH;
          end else if (stall_hit) begin
            if_stall  = 1'b1;
            id_stall  = 1'b1;
            id_bubble = 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          if (!dmem_ready) begin
            if_stall  = 1'b1;
            id_stall  = 1'b1;
            exs_stall = 1'b1;
          end else if (exs_branch_taken) begin
            if_flush    = 1'b1;
            id_bubble   = 1'b1;
            flush_cnt_d = 1'b1;
            state_d     = ST_FLUSH;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_FLUSH: begin
          if_flush = 1'b1;
          if (flush_cnt_q == 1'b0) begin
            state_d = ST_RUN;
          end else begin
            flush_cnt_d = flush_cnt_q - 1'b1;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

`ifdef ELBETH_FWD_EN
  assign match_forward_rs1 = !rst && bypass_rs1 && !id_bubble && (state_q != ST_MEM_WAIT);
  assign match_forward_rs2 = !rst && bypass_rs2 && !id_bubble && (state_q != ST_MEM_WAIT);
`else
  assign match_forward_rs1 = 1'b0;
  assign match_forward_rs2 = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      if (if_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  assign stall_count = stall_cnt_q;
  assign ctrl_state  = state_q;

endmodule

// File: tb/tb_elbeth_pipeline_ctrl.sv
// tb/tb_elbeth_pipeline_ctrl.sv - vector-table and scoreboard bench for elbeth_pipeline_ctrl
// Expectations follow ELBETH_FWD_EN so the bench suits either build.
module tb_elbeth_pipeline_ctrl;

`ifdef ELBETH_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, exs_rd_addr;
  logic       id_use_rs1, id_use_rs2, exs_w_gpr_en, exs_mem_rd;
  logic       exs_mem_req, dmem_ready, exs_branch_taken;
  logic       if_stall, id_stall, exs_stall, if_flush, id_bubble;
  logic       match_forward_rs1, match_forward_rs2;
  logic [7:0] stall_count;
  logic [1:0] ctrl_state;

  always #5 clk = ~clk;

  elbeth_pipeline_ctrl #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .exs_rd_addr(exs_rd_addr), .exs_w_gpr_en(exs_w_gpr_en),
    .exs_mem_rd(exs_mem_rd), .exs_mem_req(exs_mem_req),
    .dmem_ready(dmem_ready), .exs_branch_taken(exs_branch_taken),
    .if_stall(if_stall), .id_stall(id_stall), .exs_stall(exs_stall),
    .if_flush(if_flush), .id_bubble(id_bubble),
    .match_forward_rs1(match_forward_rs1), .match_forward_rs2(match_forward_rs2),
    .stall_count(stall_count), .ctrl_state(ctrl_state)
  );

  // exp_out = {if_stall, id_stall, exs_stall, if_flush, id_bubble, fwd_rs1, fwd_rs2}
  typedef struct {
    logic       r;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, wen, mrd, mreq, rdy, br;
    logic [6:0] exp_out;
    logic [1:0] exp_state;
  } vec_t;

  typedef struct {
    logic [6:0] o;
    logic [1:0] s;
    logic [7:0] c;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;

  task automatic add(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic u1, input logic u2, input logic [4:0] rd, input logic wen,
                     input logic mrd, input logic mreq, input logic rdy, input logic br,
                     input logic [6:0] eo, input logic [1:0] es);
    vec_t v;
    v.r = r; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd; v.wen = wen;
    v.mrd = mrd; v.mreq = mreq; v.rdy = rdy; v.br = br; v.exp_out = eo; v.exp_state = es;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s[%0d] got=%0h want=%0h", name, idx, got, want);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.r; id_rs1 = v.rs1; id_rs2 = v.rs2; id_use_rs1 = v.u1; id_use_rs2 = v.u2;
    exs_rd_addr = v.rd; exs_w_gpr_en = v.wen; exs_mem_rd = v.mrd;
    exs_mem_req = v.mreq; dmem_ready = v.rdy; exs_branch_taken = v.br;
  endtask

  initial begin
    vec_t idle;
    vec_t sat;
    exp_t e;
    logic [7:0] exp_cnt;

    idle = '{r:1'b0, rs1:5'd0, rs2:5'd0, rd:5'd0, u1:1'b0, u2:1'b0, wen:1'b0, mrd:1'b0,
             mreq:1'b0, rdy:1'b0, br:1'b0, exp_out:7'd0, exp_state:2'd0};
    idle.r = 1'b1;
    drive(idle);
    repeat (2) @(posedge clk);

    //   r  rs1 rs2 u1 u2 rd wen mrd mreq rdy br  expected outputs                    state
    add(1, 5, 0, 1, 0, 5, 1, 0, 0, 0, 0, 7'b0000000, 2'd0);
    add(0, 5, 0, 1, 0, 5, 1, 0, 0, 0, 0, FWD ? 7'b0000010 : 7'b1100100, 2'd0);
    add(0, 5, 0, 1, 0, 0, 1, 0, 0, 0, 0, 7'b0000000, 2'd0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 2'd0);
    add(0, 0, 7, 0, 1, 7, 1, 1, 0, 0, 0, 7'b1100100, 2'd0);
    add(0, 0, 7, 0, 0, 7, 1, 0, 0, 0, 0, 7'b0000000, 2'd0);
    add(0, 3, 0, 1, 0, 3, 0, 0, 0, 0, 0, 7'b0000000, 2'd0);
    add(0, 0, 7, 0, 1, 7, 1, 1, 1, 0, 1, 7'b1110000, 2'd0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 7'b1110000, 2'd1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 7'b1110000, 2'd1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 7'b0000000, 2'd1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 2'd0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7'b0001100, 2'd0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7'b0001000, 2'd2);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0001000, 2'd2);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 2'd0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 7'b1110000, 2'd0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 7'b0001100, 2'd1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0001000, 2'd2);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0001000, 2'd2);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 2'd0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 7'b1110000, 2'd0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 7'b0000000, 2'd1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 2'd0);
    add(0, 9, 9, 1, 1, 9, 1, 0, 1, 0, 0, FWD ? 7'b1110011 : 7'b1110000, 2'd0);
    add(0, 9, 9, 1, 1, 9, 1, 0, 1, 0, 0, 7'b1110000, 2'd1);
    add(0, 9, 9, 1, 1, 9, 1, 0, 1, 1, 0, 7'b0000000, 2'd1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 2'd0);
    add(0, 9, 9, 1, 1, 9, 1, 0, 0, 0, 1, 7'b0001100, 2'd0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0001000, 2'd2);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0001000, 2'd2);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 2'd0);

    exp_cnt = 8'd0;
    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      drive(vecs[i]);
      e.o = vecs[i].exp_out;
      e.s = vecs[i].exp_state;
      e.c = exp_cnt;
      sbq.push_back(e);
      #3;
      e = sbq.pop_front();
      chk("outputs", i, {25'd0, if_stall, id_stall, exs_stall, if_flush, id_bubble,
                         match_forward_rs1, match_forward_rs2}, {25'd0, e.o});
      chk("ctrl_state", i, {30'd0, ctrl_state}, {30'd0, e.s});
      chk("stall_count", i, {24'd0, stall_count}, {24'd0, e.c});
      if (vecs[i].r) exp_cnt = 8'd0;
      else if (e.o[6] && exp_cnt != 8'hff) exp_cnt = exp_cnt + 8'd1;
    end

    // Hold a memory wait long enough to push the 8-bit counter past its ceiling.
    sat = idle;
    sat.r = 1'b0;
    sat.mreq = 1'b1;
    @(posedge clk);
    #1;
    drive(sat);
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk);
      #4;
      if (n == 200) chk("sat_mid", n, {24'd0, stall_count},
                        {24'd0, ((exp_cnt + 200) > 255) ? 8'hff : exp_cnt + 8'd200});
    end
    chk("sat_final", 300, {24'd0, stall_count}, 32'd255);
    chk("sat_state", 300, {30'd0, ctrl_state}, 32'd1);
    chk("sat_stall", 300, {31'd0, if_stall}, 32'd1);

    sat.rdy = 1'b1;
    drive(sat);
    @(posedge clk);
    #4;
    chk("sat_release_state", 0, {30'd0, ctrl_state}, 32'd0);
    chk("sat_release_cnt", 0, {24'd0, stall_count}, 32'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
